// File: rtl/img_conv_pkg.sv
// -----------------------------------------------------------------------------
// img_conv_pkg
//   Shared types and constants for the image SRAM path.
//   - arb_state_t  : arbiter FSM states (idle / granted / read drain)
//   - REQ_*        : requester slot numbers on the image SRAM arbiter
//   - IMG_ARB_NREQ : number of requesters sharing the image SRAM
// -----------------------------------------------------------------------------
package img_conv_pkg;

  localparam int IMG_ARB_NREQ = 3;

  localparam int REQ_IO_RX = 0;
  localparam int REQ_IO_TX = 1;
  localparam int REQ_CONV  = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/img_rr_picker.sv
// -----------------------------------------------------------------------------
// img_rr_picker
//   Combinational round-robin selector. Scans req starting at rr_last+1
//   (wrapping modulo NREQ) and returns the first set bit as a one-hot pick.
// Ports:
//   req     in   NREQ   request vector
//   rr_last in   IDX_W  index of the most recent owner
//   pick    out  NREQ   one-hot winner (zero when nothing requests)
//   valid   out  1      at least one request present
// -----------------------------------------------------------------------------
module img_rr_picker
  import img_conv_pkg::*;
#(
  parameter  int NREQ  = IMG_ARB_NREQ,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_last,
  output logic [NREQ-1:0]  pick,
  output logic             valid
);

  int idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    // Offsets 1..NREQ: the previous owner is considered last.
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(rr_last) + i) % NREQ;
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/img_sram_arbiter.sv
// -----------------------------------------------------------------------------
// img_sram_arbiter
//   Shares the single image SRAM port between NREQ requesters with a req/gnt
//   handshake and round-robin selection. An owner keeps the port until it
//   drops req; reads still in the SRAM pipeline drain before the next grant.
//
// Optional feature: define IMG_ARB_WATCHDOG_EN to build a hold watchdog that
//   forces an owner off after MAX_HOLD granted cycles when someone else waits.
//   Without it timeout_err is constant zero and grants are unbounded.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req / gnt              per-requester request (level) / one-hot grant
//   m_row, m_col, m_din    packed per-requester address / write data
//   m_write_en, m_sense_en per-requester strobes
//   rd_data, rd_valid      read data broadcast + one-hot owner of the data
//   sram_*                 SRAM port (row, col, din, write_en, sense_en, dout)
//   busy                   FSM not idle
//   timeout_err            sticky per-requester watchdog flags
// -----------------------------------------------------------------------------
module img_sram_arbiter
  import img_conv_pkg::*;
#(
  parameter int NREQ     = IMG_ARB_NREQ,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          gnt,
  input  logic [NREQ*ADDR_W-1:0]   m_row,
  input  logic [NREQ*ADDR_W-1:0]   m_col,
  input  logic [NREQ*DATA_W-1:0]   m_din,
  input  logic [NREQ-1:0]          m_write_en,
  input  logic [NREQ-1:0]          m_sense_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [NREQ-1:0]          rd_valid,
  output logic [ADDR_W-1:0]        sram_row,
  output logic [ADDR_W-1:0]        sram_col,
  output logic [DATA_W-1:0]        sram_din,
  output logic                     sram_write_en,
  output logic                     sram_sense_en,
  input  logic [DATA_W-1:0]        sram_dout,
  output logic                     busy,
  output logic [NREQ-1:0]          timeout_err
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DCNT_W = $clog2(RD_LAT + 1);

  if (RD_LAT < 1 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("img_sram_arbiter: RD_LAT and MAX_HOLD must be >= 1");
  end

  arb_state_t         state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]   rr_last_q, rr_last_d;
  logic [DCNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [NREQ-1:0]    rd_pipe_q [RD_LAT];
  logic [NREQ-1:0]    rd_pipe_d [RD_LAT];

  logic [NREQ-1:0]    pick;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [NREQ-1:0]    eff_gnt;
  logic [NREQ-1:0]    read_push;
  logic               force_release;

  img_rr_picker #(.NREQ(NREQ)) u_picker (
    .req     (req),
    .rr_last (rr_last_q),
    .pick    (pick),
    .valid   (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  // The grant seen by the owner and the port mux drops in the same cycle
  // the owner lowers req (or the watchdog fires). Reset also blanks the port
  // so no access can start while rst is high.
  always_comb begin
    eff_gnt = '0;
    if (state_q == ARB_GRANT && !rst) begin
      eff_gnt = gnt_q & req & ~{NREQ{force_release}};
    end
  end

  assign gnt  = eff_gnt;
  assign busy = (state_q != ARB_IDLE);

  // SRAM port mux; idle values whenever nobody holds an effective grant.
  always_comb begin
    sram_row      = '0;
    sram_col      = '0;
    sram_din      = '0;
    sram_write_en = 1'b0;
    sram_sense_en = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (eff_gnt[i]) begin
        sram_row      = m_row[i*ADDR_W +: ADDR_W];
        sram_col      = m_col[i*ADDR_W +: ADDR_W];
        sram_din      = m_din[i*DATA_W +: DATA_W];
        sram_write_en = m_write_en[i];
        sram_sense_en = m_sense_en[i];
      end
    end
  end

  // A write with sense_en also high is treated as a write: nothing returns.
  assign read_push = (sram_sense_en && !sram_write_en) ? eff_gnt : '0;

  // Read-return pipe: tags each read with its owner for RD_LAT cycles.
  genvar gi;
  for (gi = 0; gi < RD_LAT; gi++) begin : g_rd_pipe
    if (gi == 0) begin : g_head
      assign rd_pipe_d[gi] = read_push;
    end else begin : g_tail
      assign rd_pipe_d[gi] = rd_pipe_q[gi-1];
    end
  end

  assign rd_valid = rd_pipe_q[RD_LAT-1];
  assign rd_data  = sram_dout;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_last_d   = rr_last_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          gnt_d     = pick;
          rr_last_d = pick_idx;
          state_d   = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (!(|(gnt_q & req)) || force_release) begin
          gnt_d       = '0;
          state_d     = ARB_DRAIN;
          drain_cnt_d = DCNT_W'(RD_LAT);
        end
      end
      ARB_DRAIN: begin
        // Requests raised here (even by the old owner) wait for ARB_IDLE.
        if (drain_cnt_q <= DCNT_W'(1)) begin
          state_d = ARB_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - DCNT_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      rr_last_q   <= IDX_W'(NREQ - 1);
      drain_cnt_q <= '0;
      rd_pipe_q   <= '{default: '0};
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_last_q   <= rr_last_d;
      drain_cnt_q <= drain_cnt_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

`ifdef IMG_ARB_WATCHDOG_EN
  localparam int HCNT_W = $clog2(MAX_HOLD + 1);

  logic [HCNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0]   timeout_err_q, timeout_err_d;

  // The counter saturates at MAX_HOLD, so a lone owner is never evicted;
  // the release fires only once a competing request shows up.
  always_comb begin
    force_release = (state_q == ARB_GRANT) &&
                    (hold_cnt_q == HCNT_W'(MAX_HOLD)) &&
                    (|(gnt_q & req)) && (|(req & ~gnt_q));
    hold_cnt_d = hold_cnt_q;
    if (state_q != ARB_GRANT) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HCNT_W'(MAX_HOLD)) begin
      hold_cnt_d = hold_cnt_q + HCNT_W'(1);
    end
    timeout_err_d = timeout_err_q | (force_release ? gnt_q : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q    <= '0;
      timeout_err_q <= '0;
    end else begin
      hold_cnt_q    <= hold_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign force_release = 1'b0;
  assign timeout_err   = '0;
`endif

endmodule
